// File: rtl/p_mul_pkg.sv
// Shared definitions for the packed-multiply sequencer: one-hot pack widths and FSM encoding.
// No logic of its own; pw_ok() is a pure combinational helper.
// No flow control here; consumers apply these constants to their own handshakes.
package p_mul_pkg;

  // One-hot pack-width encodings as seen on req_pw / mul_pw
  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_e;

  // True when pw is exactly one-hot and that width is enabled in mask
  function automatic logic pw_ok(input logic [4:0] pw, input logic [4:0] mask);
    return (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0) && ((pw & ~mask) == 5'd0);
  endfunction

endpackage

// File: rtl/p_mul_wide.sv
// Full 64-bit packed multiply built from two p_mul transactions (low half, then high half).
// Latency 3 cycles accept->rsp_valid with mul_ready held high; one request per 4 cycles.
// Backpressure: mul_valid waits indefinitely for mul_ready, rsp_* held until rsp_ready; req_ready only in IDLE.
// Optional pack-width checking is enabled by defining P_MUL_WIDE_ERR_EN.
module p_mul_wide
  import p_mul_pkg::*;
#(
  parameter logic [4:0] PW_MASK = 5'b11111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_pw,
  input  logic        req_clmul,
  input  logic [31:0] req_crs1,
  input  logic [31:0] req_crs2,
  output logic        mul_valid,
  input  logic        mul_ready,
  output logic        mul_l,
  output logic        mul_h,
  output logic        mul_clmul,
  output logic [4:0]  mul_pw,
  output logic [31:0] mul_crs1,
  output logic [31:0] mul_crs2,
  input  logic [31:0] mul_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err
);

`ifdef P_MUL_WIDE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [4:0]  pw_q, pw_d;
  logic        clmul_q, clmul_d;
  logic [31:0] crs1_q, crs1_d;
  logic [31:0] crs2_q, crs2_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        err_q, err_d;

  // Handshake and datapath outputs decode straight from registered state
  assign req_ready = (state_q == IDLE) && !reset;
  assign mul_valid = (state_q == LO) || (state_q == HI);
  assign mul_l     = (state_q == LO);
  assign mul_h     = !mul_l;
  assign mul_pw    = pw_q;
  assign mul_clmul = clmul_q;
  assign mul_crs1  = crs1_q;
  assign mul_crs2  = crs2_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_err   = err_q;

  // Next-state: latch request in IDLE, collect the two halves, then hold the response
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    clmul_d = clmul_q;
    crs1_d  = crs1_q;
    crs2_d  = crs2_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pw_d    = req_pw;
          clmul_d = req_clmul;
          crs1_d  = req_crs1;
          crs2_d  = req_crs2;
          // Clear the result so a rejected width reports zeros
          lo_d    = 32'd0;
          hi_d    = 32'd0;
          err_d   = ERR_EN && !pw_ok(req_pw, PW_MASK);
          state_d = err_d ? RSP : LO;
        end
      end
      LO: begin
        if (mul_ready) begin
          lo_d    = mul_result;
          state_d = HI;
        end
      end
      HI: begin
        if (mul_ready) begin
          hi_d    = mul_result;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pw_q    <= 5'd0;
      clmul_q <= 1'b0;
      crs1_q  <= 32'd0;
      crs2_q  <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      clmul_q <= clmul_d;
      crs1_q  <= crs1_d;
      crs2_q  <= crs2_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_p_mul_wide.sv
// Bench for p_mul_wide with a behavioural p_mul model answering each half-transaction.
// Table vectors with hand-computed results, randomized requests against a lane-wise reference,
// and hand sequences for reset behaviour.
module tb_p_mul_wide;
  import p_mul_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_pw = 5'd0;
  logic        req_clmul = 1'b0;
  logic [31:0] req_crs1 = 32'd0;
  logic [31:0] req_crs2 = 32'd0;
  logic        mul_valid;
  logic        mul_ready = 1'b0;
  logic        mul_l, mul_h, mul_clmul;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1, mul_crs2, mul_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  p_mul_wide dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pw(req_pw), .req_clmul(req_clmul),
    .req_crs1(req_crs1), .req_crs2(req_crs2),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_l(mul_l), .mul_h(mul_h),
    .mul_clmul(mul_clmul), .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2),
    .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_err(rsp_err)
  );

  // Packed product: each lane's double-width product split into low and high lane halves
  function automatic logic [63:0] ref_prod(input logic [4:0] pw, input logic clmul,
                                           input logic [31:0] a, input logic [31:0] b);
    int w;
    longint unsigned m, x, y, p, lo, hi, aa, bb;
    case (pw)
      PW_16:   w = 16;
      PW_8:    w = 8;
      PW_4:    w = 4;
      PW_2:    w = 2;
      default: w = 32;
    endcase
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, a};
    bb = {32'd0, b};
    lo = 0;
    hi = 0;
    for (int i = 0; i < 32 / w; i++) begin
      x = (aa >> (i * w)) & m;
      y = (bb >> (i * w)) & m;
      if (clmul) begin
        p = 0;
        for (int j = 0; j < w; j++) if (y[j]) p = p ^ (x << j);
      end else begin
        p = x * y;
      end
      lo = lo | ((p & m) << (i * w));
      hi = hi | (((p >> w) & m) << (i * w));
    end
    return {hi[31:0], lo[31:0]};
  endfunction

  function automatic logic [31:0] pmul_model(input logic [4:0] pw, input logic clmul,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic l);
    logic [63:0] f;
    f = ref_prod(pw, clmul, a, b);
    return l ? f[31:0] : f[63:32];
  endfunction

  assign mul_result = pmul_model(mul_pw, mul_clmul, mul_crs1, mul_crs2, mul_l);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one request, apply mul/rsp stalls, and report what the DUT returned
  task automatic run_req(input logic [4:0] pw, input logic clmul, input logic [31:0] a,
                         input logic [31:0] b, input int s_lo, input int s_hi, input int s_rsp,
                         input string tag, output logic [31:0] lo, output logic [31:0] hi,
                         output logic err, output int lat, output int ntx,
                         output logic [1:0] order);
    int c, wl, wh, wr, stab_bad, held_bad;
    bit done;
    lo = 0; hi = 0; err = 0; lat = -1; ntx = 0; order = 2'b00;
    c = 0; wl = 0; wh = 0; wr = 0; stab_bad = 0; held_bad = 0; done = 0;
    @(negedge clock);
    chk({tag, ":req_ready_idle"}, req_ready, 1);
    req_valid = 1; req_pw = pw; req_clmul = clmul; req_crs1 = a; req_crs2 = b;
    mul_ready = 0; rsp_ready = 0;
    @(posedge clock);
    while (!done && c < 200) begin
      @(negedge clock);
      c++;
      req_valid = 0; mul_ready = 0; rsp_ready = 0;
      if (mul_valid) begin
        if (mul_pw !== pw || mul_crs1 !== a || mul_crs2 !== b || mul_clmul !== clmul ||
            mul_h !== !mul_l) stab_bad++;
        if (mul_l) begin mul_ready = (wl >= s_lo); wl++; end
        else       begin mul_ready = (wh >= s_hi); wh++; end
        if (mul_ready) begin order = {order[0], mul_l}; ntx++; end
      end
      if (rsp_valid) begin
        if (wr == 0) begin
          lat = c; lo = rsp_lo; hi = rsp_hi; err = rsp_err;
        end else if (rsp_lo !== lo || rsp_hi !== hi || rsp_err !== err) begin
          held_bad++;
        end
        if (req_ready !== 1'b0) held_bad++;
        rsp_ready = (wr >= s_rsp);
        if (!rsp_ready) begin
          // A competing request while the response is pending must be ignored
          req_valid = 1; req_pw = PW_8; req_crs1 = $urandom; req_crs2 = $urandom;
        end
        wr++;
        if (rsp_ready) done = 1;
      end
    end
    chk({tag, ":completed"}, done, 1);
    chk({tag, ":mul_stable"}, stab_bad, 0);
    chk({tag, ":rsp_held"}, held_bad, 0);
    @(negedge clock);
    req_valid = 0; rsp_ready = 0; mul_ready = 0;
    chk({tag, ":back_to_idle"}, req_ready, 1);
  endtask

  typedef struct {
    logic [4:0]  pw;
    logic        clmul;
    logic [31:0] a, b, lo, hi;
    int          s_lo, s_hi, s_rsp;
    bit          inv;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] lo, hi;
    logic        err;
    int          lat, ntx, exp_lat;
    logic [1:0]  order;
    logic [63:0] exp;
    string       tag;

    tbl[0]  = '{PW_32, 1'b0, 32'h10, 32'h10, 32'h00000100, 32'h0, 0, 0, 0, 1'b0};
    tbl[1]  = '{PW_16, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010001, 32'hFFFEFFFE, 0, 0, 0, 1'b0};
    tbl[2]  = '{PW_32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 1'b0};
    tbl[3]  = '{PW_8, 1'b0, 32'h02030405, 32'h02020202, 32'h0406080A, 32'h0, 3, 3, 0, 1'b0};
    tbl[4]  = '{PW_32, 1'b1, 32'h3, 32'h3, 32'h5, 32'h0, 0, 0, 0, 1'b0};
    tbl[5]  = '{PW_32, 1'b1, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1, 0, 0, 1'b0};
    tbl[6]  = '{PW_4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 32'h55555555, 0, 2, 0, 1'b0};
    tbl[7]  = '{PW_2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA, 0, 0, 0, 1'b0};
    tbl[8]  = '{PW_16, 1'b0, 32'h00030002, 32'h00050007, 32'h000F000E, 32'h0, 0, 0, 5, 1'b0};
    tbl[9]  = '{5'b00011, 1'b0, 32'h1234, 32'h5678, 32'h0, 32'h0, 0, 0, 0, 1'b1};
    tbl[10] = '{5'b00000, 1'b0, 32'h9, 32'h9, 32'h0, 32'h0, 0, 0, 2, 1'b1};

    // Reset state, checked mid-cycle while reset is held
    #3;
    chk("rst:req_ready", req_ready, 0);
    chk("rst:mul_valid", mul_valid, 0);
    chk("rst:mul_l", mul_l, 0);
    chk("rst:mul_h", mul_h, 1);
    chk("rst:rsp_valid", rsp_valid, 0);
    chk("rst:rsp_lo_hi_err", {rsp_lo, rsp_hi[30:0], rsp_err}, 64'd0);
    chk("rst:mul_bus", {mul_pw, mul_clmul, mul_crs1, mul_crs2[25:0]}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 0;
    #1;
    chk("rst:req_ready_after_release", req_ready, 1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      run_req(tbl[i].pw, tbl[i].clmul, tbl[i].a, tbl[i].b, tbl[i].s_lo, tbl[i].s_hi,
              tbl[i].s_rsp, tag, lo, hi, err, lat, ntx, order);
      if (!tbl[i].inv) begin
        chk({tag, ":lo"}, lo, tbl[i].lo);
        chk({tag, ":hi"}, hi, tbl[i].hi);
        chk({tag, ":err"}, err, 0);
        chk({tag, ":latency"}, lat, 3 + tbl[i].s_lo + tbl[i].s_hi);
        chk({tag, ":transfers"}, ntx, 2);
        chk({tag, ":order"}, order, 2'b10);
      end else begin
`ifdef P_MUL_WIDE_ERR_EN
        chk({tag, ":lo"}, lo, 0);
        chk({tag, ":hi"}, hi, 0);
        chk({tag, ":err"}, err, 1);
        chk({tag, ":latency"}, lat, 1);
        chk({tag, ":transfers"}, ntx, 0);
`else
        chk({tag, ":err"}, err, 0);
        chk({tag, ":latency"}, lat, 3);
        chk({tag, ":transfers"}, ntx, 2);
        chk({tag, ":order"}, order, 2'b10);
`endif
      end
    end

    // Randomized requests against the lane-wise reference
    for (int i = 0; i < 40; i++) begin
      logic [4:0]  pw;
      logic        cm;
      logic [31:0] a, b;
      int          sl, sh, sr;
      pw = 5'd1 << $urandom_range(0, 4);
      cm = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      sl = $urandom_range(0, 2);
      sh = $urandom_range(0, 2);
      sr = $urandom_range(0, 2);
      tag = $sformatf("rnd%0d", i);
      run_req(pw, cm, a, b, sl, sh, sr, tag, lo, hi, err, lat, ntx, order);
      exp = ref_prod(pw, cm, a, b);
      exp_lat = 3 + sl + sh;
      chk({tag, ":product"}, {hi, lo}, exp);
      chk({tag, ":latency"}, lat, exp_lat);
      chk({tag, ":transfers"}, ntx, 2);
    end

    // Reset pulsed during the high-half transaction
    begin
      int seen;
      @(negedge clock);
      req_valid = 1; req_pw = PW_32; req_clmul = 0; req_crs1 = 32'h7; req_crs2 = 32'h9;
      @(posedge clock);
      @(negedge clock);
      req_valid = 0;
      chk("rhi:in_lo", {mul_valid, mul_l}, 2'b11);
      mul_ready = 1;
      @(negedge clock);
      chk("rhi:in_hi", {mul_valid, mul_l}, 2'b10);
      mul_ready = 0;
      #1 reset = 1;
      #1;
      chk("rhi:mul_valid_drop", mul_valid, 0);
      chk("rhi:rsp_valid_low", rsp_valid, 0);
      chk("rhi:partial_discarded", rsp_lo, 0);
      chk("rhi:mul_h", mul_h, 1);
      chk("rhi:req_ready_in_reset", req_ready, 0);
      @(negedge clock); @(negedge clock);
      reset = 0;
      #1;
      chk("rhi:req_ready_after", req_ready, 1);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clock);
        if (rsp_valid || mul_valid) seen++;
      end
      chk("rhi:no_activity", seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
